serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader.sv | 147 ++++++++++++++
 tb/tb_serial_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// Serial-to-parallel loader: assembles N LSB-first serial bits into a word and pulses load.
// Define SERIAL_LOADER_PARITY_EN to expect a trailing odd-parity bit per word.
module serial_loader #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         sin,
  input  logic         sin_valid,
  output logic [N-1:0] P,
  output logic         load,
  output logic         busy,
  output logic         parity_err
);

  localparam int CW = $clog2(N + 1);

`ifdef SERIAL_LOADER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [N-1:0]  shadow, shadow_n;
  logic [N-1:0]  p_n;
  logic          load_n;
  logic          busy_n;
`ifdef SERIAL_LOADER_PARITY_EN
  logic          perr_q, perr_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // All outputs are registered copies of the next-state decode, so nothing
  // combinational reaches the ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      shadow <= '0;
      P      <= '0;
      load   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      count  <= count_n;
      shadow <= shadow_n;
      P      <= p_n;
      load   <= load_n;
      busy   <= busy_n;
    end
  end

`ifdef SERIAL_LOADER_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_n;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    count_n  = count;
    shadow_n = shadow;
    p_n      = P;
    load_n   = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
    perr_n   = perr_q;
`endif

    if (clear) begin
      state_n  = IDLE;
      count_n  = '0;
      shadow_n = '0;
    end else begin
      case (state)
        // DONE behaves like IDLE so a bit arriving during the load cycle starts the next word.
        IDLE, DONE: begin
          state_n = IDLE;
          if (sin_valid) begin
            shadow_n    = '0;
            shadow_n[0] = sin;
            count_n     = CW'(1);
            state_n     = SHIFT;
          end
        end

        SHIFT: begin
          if (sin_valid) begin
            for (int i = 0; i < N; i++) begin
              if (count == CW'(i)) shadow_n[i] = sin;
            end
            if (count == CW'(N - 1)) begin
              count_n = '0;
`ifdef SERIAL_LOADER_PARITY_EN
              state_n = PAR;
`else
              state_n = DONE;
              load_n  = 1'b1;
              p_n     = shadow_n;
`endif
            end else begin
              count_n = count + CW'(1);
            end
          end
        end

`ifdef SERIAL_LOADER_PARITY_EN
        // Odd parity: data bits plus parity bit must XOR to 1.
        PAR: begin
          if (sin_valid) begin
            state_n = DONE;
            load_n  = 1'b1;
            p_n     = shadow;
            perr_n  = ~(^shadow ^ sin);
          end
        end
`endif

        default: begin
          state_n = IDLE;
        end
      endcase
    end

`ifdef SERIAL_LOADER_PARITY_EN
    busy_n = (state_n == SHIFT) || (state_n == PAR);
`else
    busy_n = (state_n == SHIFT);
`endif
  end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (N=4) with a scoreboard of expected words
// checked whenever load pulses; follows SERIAL_LOADER_PARITY_EN if defined.
module tb_serial_loader;

  localparam int N = 4;
`ifdef SERIAL_LOADER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int WORD_CYC = N + (PAR_EN ? 1 : 0);

  typedef struct {
    logic [N-1:0] p;
    logic         perr;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         sin;
  logic         sin_valid;
  logic [N-1:0] P;
  logic         load;
  logic         busy;
  logic         parity_err;

  int   passed = 0;
  int   total  = 0;
  int   load_count = 0;
  int   cyc = 0;
  int   load_cyc[$];
  exp_t sb[$];
  exp_t mon_e;
  logic prev_load = 1'b0;

  serial_loader #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .P          (P),
    .load       (load),
    .busy       (busy),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Drive one cycle of inputs, then return just after the capturing edge.
  task automatic applyStimulus(input logic s, input logic v, input logic c);
    sin       = s;
    sin_valid = v;
    clear     = c;
    @(posedge clk);
    #1;
    sin       = 1'b0;
    sin_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic sendWord(input logic [N-1:0] w, input int gap, input logic flip);
    exp_t e;
    e.p    = w;
    e.perr = PAR_EN ? flip : 1'b0;
    sb.push_back(e);
    for (int i = 0; i < N; i++) begin
      applyStimulus(w[i], 1'b1, 1'b0);
      if (i < N - 1 || PAR_EN) begin
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, 1'b0, 1'b0);
          checkOutput("busy_gap", {31'b0, busy}, 32'd1);
        end
      end
    end
    if (PAR_EN) applyStimulus((~^w) ^ flip, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (load) begin
      checkOutput("load_single_pulse", {31'b0, prev_load}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_load", {31'b0, load}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("word_P", {28'b0, P}, {28'b0, mon_e.p});
        checkOutput("word_parity_err", {31'b0, parity_err}, {31'b0, mon_e.perr});
      end
      load_count++;
      load_cyc.push_back(cyc);
    end
    prev_load = load;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_P", {28'b0, P}, 32'd0);
    checkOutput("reset_load", {31'b0, load}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_parity_err", {31'b0, parity_err}, 32'd0);
    reset = 1'b0;

    $display("[TB] basic word, first edge after reset");
    sendWord(4'b1101, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("basic_load_drop", {31'b0, load}, 32'd0);
    checkOutput("basic_busy_idle", {31'b0, busy}, 32'd0);
    checkOutput("basic_load_count", load_count, 32'd1);

    $display("[TB] word with 3-cycle gaps");
    sendWord(4'b1101, 3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("gap_load_drop", {31'b0, load}, 32'd0);
    checkOutput("gap_load_count", load_count, 32'd2);

    $display("[TB] back-to-back words");
    sendWord(4'b0011, 0, 1'b0);
    sendWord(4'b1010, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("b2b_load_count", load_count, 32'd4);
    checkOutput("b2b_spacing", load_cyc[3] - load_cyc[2], WORD_CYC);

    $display("[TB] async reset mid-word");
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("midword_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_reset_P", {28'b0, P}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sendWord(4'b1000, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_word_load_count", load_count, 32'd5);

    $display("[TB] clear after three bits");
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clear_busy", {31'b0, busy}, 32'd0);
    checkOutput("clear_P_hold", {28'b0, P}, 32'h8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clear_P_hold_later", {28'b0, P}, 32'h8);
    checkOutput("clear_no_load", load_count, 32'd5);
    sendWord(4'b1111, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("clear_word_load_count", load_count, 32'd6);

    $display("[TB] parity good and bad");
    sendWord(4'b1101, 0, 1'b0);
    sendWord(4'b1101, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("parity_load_count", load_count, 32'd8);
    checkOutput("parity_err_hold", {31'b0, parity_err}, {31'b0, PAR_EN});

    $display("[TB] clear during load cycle");
    sendWord(4'b0110, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("done_clear_busy", {31'b0, busy}, 32'd0);
    sendWord(4'b0101, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("done_clear_load_count", load_count, 32'd10);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
